// File: rtl/fb_writer_pkg.sv
// Shared types and helpers for the framebuffer writer slice.
package fb_writer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] data;
  } fb_entry_t;

  localparam logic [1:0] FB_BYTEENABLE = 2'b11;

  // Pixel index to SDRAM byte address; wraps silently modulo 2^32.
  function automatic logic [31:0] fb_byte_addr(input logic [31:0] base,
                                               input logic [31:0] idx,
                                               input int shift);
    return base + (idx << shift);
  endfunction

endpackage

// File: rtl/framebuffer_writer_fifo.sv
// Synchronous FIFO with a registered head word. The pointers carry an
// extra MSB so that full and empty can be told apart without a counter.
// rdata always holds the entry at the read pointer, so a consumer can
// take it in the same edge that it pops.
module sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == FULL_CNT);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign level   = count;
  assign rdata   = head_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Advance pointers and prefetch the entry that will be at the head after this edge.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    head_d   = mem_q[rd_ptr_d[AW-1:0]];
    // The new head slot is only being written when the FIFO drains to
    // empty in this edge; forward the incoming word in that case.
    if (push_ok && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
      head_d = wdata;
    end
  end

  // Storage array; data only, never reset.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

  // Pointer and head registers.
  always_ff @(posedge clock) begin
    head_q <= head_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/framebuffer_writer.sv
// Framebuffer writer: buffers single-pixel write requests from the solver
// write arbitrator and issues them as Avalon-MM writes to SDRAM.
// Optional build macro FB_WRITER_STATS_EN adds write and stall counters.
module framebuffer_writer
  import fb_writer_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          ADDR_SHIFT = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [15:0]                    in_data,
  input  logic [31:0]                    in_addr,
  input  logic                           in_write_en,
  output logic                           in_ack,
  output logic [31:0]                    avm_address,
  output logic                           avm_write,
  output logic [15:0]                    avm_writedata,
  output logic [1:0]                     avm_byteenable,
  input  logic                           avm_waitrequest,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           idle
`ifdef FB_WRITER_STATS_EN
  ,
  output logic [31:0]                    stat_writes,
  output logic [31:0]                    stat_stall_cycles
`endif
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  fb_entry_t   push_entry;
  fb_entry_t   head_entry;
  logic        fifo_full;
  logic        fifo_empty;
  logic [LW-1:0] fifo_level_w;
  logic        accept;
  logic        pop;
  logic [LW-1:0] level_nxt;

  state_t      state_q, state_d;
  logic        in_ack_q, in_ack_d;
  logic        avm_write_q, avm_write_d;
  logic [31:0] avm_address_q, avm_address_d;
  logic [15:0] avm_writedata_q, avm_writedata_d;
  logic        idle_q, idle_d;

  // The cycle carrying in_ack still sees in_write_en high from upstream, so it must not count as a new request.
  assign accept          = in_write_en && !in_ack_q && !fifo_full;
  assign in_ack_d        = accept;
  assign push_entry.addr = fb_byte_addr(BASE_ADDR, in_addr, ADDR_SHIFT);
  assign push_entry.data = in_data;

  sync_fifo #(
    .WIDTH ($bits(fb_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (accept),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level_w)
  );

  // Avalon write sequencer: load the head on pop, hold while stalled, stream back-to-back.
  always_comb begin
    state_d         = state_q;
    avm_write_d     = avm_write_q;
    avm_address_d   = avm_address_q;
    avm_writedata_d = avm_writedata_q;
    pop             = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop             = 1'b1;
          avm_address_d   = head_entry.addr;
          avm_writedata_d = head_entry.data;
          avm_write_d     = 1'b1;
          state_d         = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!avm_waitrequest) begin
          if (!fifo_empty) begin
            pop             = 1'b1;
            avm_address_d   = head_entry.addr;
            avm_writedata_d = head_entry.data;
          end else begin
            avm_write_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
      end
    endcase
  end

  // Idle reflects the occupancy and state that will hold after this edge.
  always_comb begin
    level_nxt = fifo_level_w + LW'(accept) - LW'(pop);
    idle_d    = (level_nxt == '0) && (state_d == ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      in_ack_q        <= 1'b0;
      avm_write_q     <= 1'b0;
      avm_address_q   <= '0;
      avm_writedata_q <= '0;
      idle_q          <= 1'b1;
    end else begin
      state_q         <= state_d;
      in_ack_q        <= in_ack_d;
      avm_write_q     <= avm_write_d;
      avm_address_q   <= avm_address_d;
      avm_writedata_q <= avm_writedata_d;
      idle_q          <= idle_d;
    end
  end

  assign in_ack         = in_ack_q;
  assign avm_write      = avm_write_q;
  assign avm_address    = avm_address_q;
  assign avm_writedata  = avm_writedata_q;
  assign avm_byteenable = FB_BYTEENABLE;
  assign fifo_level     = fifo_level_w;
  assign idle           = idle_q;

`ifdef FB_WRITER_STATS_EN
  logic [31:0] stat_writes_q, stat_writes_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  // A write completes on any edge where it is presented without a stall.
  always_comb begin
    stat_writes_d = stat_writes_q + {31'd0, (avm_write_q && !avm_waitrequest)};
    stat_stall_d  = stat_stall_q + {31'd0, (avm_write_q && avm_waitrequest)};
  end

  // Free-running statistics counters, wrapping at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_writes_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_writes_q <= stat_writes_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_writes       = stat_writes_q;
  assign stat_stall_cycles = stat_stall_q;
`endif

endmodule
